// File: rtl/md_scheduler.sv
// Multiply/divide sequencer beside the E-stage ALU; owns HI/LO and raises the D-stage stall.
// Optional build macro: MD_DIV0_FAST_EN (divide by zero completes without entering RUN).
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDOpE,
  input  logic [3:0]  MDOpD,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  output logic        Start,
  output logic        Busy,
  output logic        StallMD,
  output logic [31:0] ResultMD,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CW = 16;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_count;
  logic           r_busy;
  logic           r_nowr;
  logic [31:0]    r_hi, r_lo, r_sh, r_sl;

  logic           w_is_mdu_e, w_is_mdu_d, w_is_div, w_b_zero, w_div0_skip;
  logic [63:0]    w_a_sx, w_b_sx, w_prod_s, w_prod_u;
  logic [31:0]    w_b_sdiv, w_b_udiv;
  logic signed [31:0] w_q_s, w_r_s;
  logic [31:0]    w_q_u, w_r_u;

  assign w_is_mdu_e = (MDOpE >= 4'd1) && (MDOpE <= 4'd4);
  assign w_is_mdu_d = (MDOpD >= 4'd1) && (MDOpD <= 4'd8);
  assign w_is_div   = (MDOpE == 4'd3) || (MDOpE == 4'd4);
  assign w_b_zero   = (SrcBE == 32'd0);

`ifdef MD_DIV0_FAST_EN
  assign w_div0_skip = w_is_div && w_b_zero;
`else
  assign w_div0_skip = 1'b0;
`endif

  assign w_a_sx   = {{32{SrcAE[31]}}, SrcAE};
  assign w_b_sx   = {{32{SrcBE[31]}}, SrcBE};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {32'd0, SrcAE} * {32'd0, SrcBE};

  // Dividing by 1 in the overflow case yields exactly q=0x80000000, r=0; a zero divisor is
  // replaced so the divider never sees it (its result is discarded anyway).
  assign w_b_sdiv = (w_b_zero || (SrcAE == 32'h8000_0000 && SrcBE == 32'hFFFF_FFFF))
                    ? 32'd1 : SrcBE;
  assign w_b_udiv = w_b_zero ? 32'd1 : SrcBE;
  assign w_q_s    = $signed(SrcAE) / $signed(w_b_sdiv);
  assign w_r_s    = $signed(SrcAE) % $signed(w_b_sdiv);
  assign w_q_u    = SrcAE / w_b_udiv;
  assign w_r_u    = SrcAE % w_b_udiv;

  assign Start    = w_is_mdu_e && (r_state == S_IDLE);
  assign Busy     = r_busy;
  assign StallMD  = w_is_mdu_d && (r_busy || Start);
  assign HI       = r_hi;
  assign LO       = r_lo;

  always_comb begin
    ResultMD = 32'd0;
    if (MDOpE == 4'd5)      ResultMD = r_hi;
    else if (MDOpE == 4'd6) ResultMD = r_lo;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_nowr  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_sh    <= 32'd0;
      r_sl    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start && !w_div0_skip) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_nowr  <= w_is_div && w_b_zero;
            r_count <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            case (MDOpE)
              4'd1:    {r_sh, r_sl} <= w_prod_s;
              4'd2:    {r_sh, r_sl} <= w_prod_u;
              4'd3:    {r_sh, r_sl} <= {w_r_s, w_q_s};
              default: {r_sh, r_sl} <= {w_r_u, w_q_u};
            endcase
          end else if (MDOpE == 4'd7) begin
            r_hi <= SrcAE;
          end else if (MDOpE == 4'd8) begin
            r_lo <= SrcAE;
          end
        end
        // Any E-stage op arriving here is a protocol violation and is ignored.
        S_RUN: begin
          if (r_count == CW'(1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (!r_nowr) begin
              r_hi <= r_sh;
              r_lo <= r_sl;
            end
          end else begin
            r_count <= r_count - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_scheduler.sv
// Directed, table-driven bench for md_scheduler with hand-computed HI/LO results.
module tb_md_scheduler;

  logic        clk, reset;
  logic [3:0]  MDOpE, MDOpD;
  logic [31:0] SrcAE, SrcBE;
  logic        Start, Busy, StallMD;
  logic [31:0] ResultMD, HI, LO;

  int checks = 0;
  int errors = 0;

  md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDOpE(MDOpE), .MDOpD(MDOpD),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .Start(Start), .Busy(Busy),
    .StallMD(StallMD), .ResultMD(ResultMD), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    int          cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue op for one cycle, then count cycles with Busy high (bounded).
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cyc);
    MDOpE = op; SrcAE = a; SrcBE = b;
    #1;
    check("start_pulse", {31'd0, Start}, 32'd1);
    tick;
    MDOpE = 4'd0;
    cyc = 0;
    while (Busy === 1'b1 && cyc < 60) begin
      cyc++;
      tick;
    end
  endtask

  initial begin
    int cyc;
    int stalls;
    vecs[0] = '{4'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{4'd4, 32'd7,        32'd2,        32'd1,        32'd3,        10};
    vecs[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10};
    vecs[5] = '{4'd1, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 5};
    vecs[6] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
    vecs[7] = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[8] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[9] = '{4'd4, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 10};

    reset = 1'b1; MDOpE = 4'd0; MDOpD = 4'd6; SrcAE = 32'd0; SrcBE = 32'd0;
    #1;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_stall", {31'd0, StallMD}, 32'd0);
    check("rst_start", {31'd0, Start}, 32'd0);
    tick; tick;
    reset = 1'b0; MDOpD = 4'd0;
    tick;

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
      check($sformatf("v%0d_busy_cycles", i), cyc, vecs[i].cyc);
      check($sformatf("v%0d_hi", i), HI, vecs[i].hi);
      check($sformatf("v%0d_lo", i), LO, vecs[i].lo);
      MDOpE = 4'd5; #1;
      check($sformatf("v%0d_mfhi", i), ResultMD, vecs[i].hi);
      MDOpE = 4'd6; #1;
      check($sformatf("v%0d_mflo", i), ResultMD, vecs[i].lo);
      MDOpE = 4'd9; #1;
      check($sformatf("v%0d_res_none", i), ResultMD, 32'd0);
      MDOpE = 4'd0;
      tick;
    end

    // mthi then mfhi; LO untouched
    MDOpE = 4'd7; SrcAE = 32'h12345678; tick;
    MDOpE = 4'd5; #1;
    check("mthi_mfhi", ResultMD, 32'h12345678);
    check("mthi_lo_kept", LO, 32'h0FFFFFFF);
    MDOpE = 4'd8; SrcAE = 32'hA5A5A5A5; tick;
    MDOpE = 4'd7; tick;
    MDOpE = 4'd0;
    check("mtlo_lo", LO, 32'hA5A5A5A5);
    check("mthi_hi", HI, 32'hA5A5A5A5);

    // divide by zero leaves HI/LO alone
    MDOpD = 4'd6;
    MDOpE = 4'd3; SrcAE = 32'd100; SrcBE = 32'd0; #1;
    check("div0_stall_issue", {31'd0, StallMD}, 32'd1);
    MDOpD = 4'd0;
    issue(4'd3, 32'd100, 32'd0, cyc);
`ifdef MD_DIV0_FAST_EN
    check("div0_busy_cycles", cyc, 0);
`else
    check("div0_busy_cycles", cyc, 10);
`endif
    check("div0_hi", HI, 32'hA5A5A5A5);
    check("div0_lo", LO, 32'hA5A5A5A5);
    tick;

    // mult with mflo waiting in D: stall through issue and every Busy cycle
    MDOpE = 4'd1; SrcAE = 32'd3; SrcBE = 32'd5; MDOpD = 4'd6; #1;
    check("stall_issue", {31'd0, StallMD}, 32'd1);
    tick;
    MDOpE = 4'd0;
    stalls = 0;
    while (StallMD === 1'b1 && stalls < 60) begin
      if (Busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_without_busy: cycle %0d", stalls);
      end
      stalls++;
      tick;
    end
    check("stall_cycles", stalls, 5);
    check("stall_busy_drop", {31'd0, Busy}, 32'd0);
    MDOpE = 4'd6; MDOpD = 4'd0; #1;
    check("stall_mflo_new", ResultMD, 32'd15);
    MDOpE = 4'd0;
    tick;

    // ops arriving in E while Busy are ignored
    MDOpE = 4'd2; SrcAE = 32'd6; SrcBE = 32'd7; tick;
    MDOpE = 4'd7; SrcAE = 32'hDEADBEEF; #1;
    check("busy_no_start", {31'd0, Start}, 32'd0);
    tick;
    MDOpE = 4'd1; SrcAE = 32'd9; SrcBE = 32'd9; tick;
    MDOpE = 4'd0;
    cyc = 0;
    while (Busy === 1'b1 && cyc < 60) begin cyc++; tick; end
    check("ignore_cycles_left", cyc, 3);
    check("ignore_hi", HI, 32'd0);
    check("ignore_lo", LO, 32'd42);
    tick;

    // reset in the middle of a divide
    MDOpE = 4'd4; SrcAE = 32'd7; SrcBE = 32'd2; tick;
    MDOpE = 4'd0;
    tick; tick; tick;
    reset = 1'b1; #1;
    check("midrst_busy", {31'd0, Busy}, 32'd0);
    check("midrst_hi", HI, 32'd0);
    check("midrst_lo", LO, 32'd0);
    tick;
    reset = 1'b0;
    tick;
    issue(4'd2, 32'd3, 32'd5, cyc);
    check("postrst_cycles", cyc, 5);
    check("postrst_lo", LO, 32'd15);
    check("postrst_hi", HI, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
